phoenix_pwm_generator: RTL and testbench

Consumes the `pwm_cycle` / `pwm_duty` pair published by the LED controller and turns it into a glitch-free single-bit PWM waveform for the LED pin. It sits between the controller and the top-level LED output. New settings are latched only at period boundaries, so a mid-period change never produces a runt pulse. It also reports period starts and out-of-range duty requests.

---
 rtl/phoenix_pwm_pkg.sv | 16 +
 rtl/phoenix_pwm_generator.sv | 97 +++++++++
 tb/tb_phoenix_pwm_generator.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/phoenix_pwm_pkg.sv
// Shared definitions for the PWM generator and the LED controller.
//   pwm_state_e          : PWM sequencing states (idle / running / draining)
//   DEFAULT_COUNTER_BITS : default width of cycle, duty and position counter
//   DEFAULT_MIN_CYCLE    : smallest period length treated as runnable
package phoenix_pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } pwm_state_e;

  localparam int DEFAULT_COUNTER_BITS = 32;
  localparam int DEFAULT_MIN_CYCLE    = 2;

endpackage

// File: rtl/phoenix_pwm_generator.sv
// Glitch-free PWM generator for the LED pin.
// Settings are latched into shadow registers only at period boundaries, so a
// change arriving mid-period never produces a runt pulse.
//
// Ports:
//   clk          : block clock
//   reset        : synchronous, active-low reset
//   enable       : run request
//   pwm_cycle    : period length in clk cycles
//   pwm_duty     : active cycles per period
//   pwm_out      : registered PWM output (polarity set by INVERT_OUTPUT)
//   period_start : strobe in the first cycle of every period
//   duty_clamped : latched duty >= latched cycle for the running period
//   counter      : position within the current period (debug)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | outputs inactive, waiting for enable with a runnable cycle
// ST_RUN   | emitting periods, reloading settings at every wrap
// ST_DRAIN | enable dropped; finish the current period, then go idle
module phoenix_pwm_generator
  import phoenix_pwm_pkg::*;
#(
  parameter int PWM_COUNTER_BITS = DEFAULT_COUNTER_BITS,
  parameter int MIN_CYCLE        = DEFAULT_MIN_CYCLE,
  parameter bit INVERT_OUTPUT    = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [PWM_COUNTER_BITS-1:0] pwm_cycle,
  input  logic [PWM_COUNTER_BITS-1:0] pwm_duty,
  output logic                        pwm_out,
  output logic                        period_start,
  output logic                        duty_clamped,
  output logic [PWM_COUNTER_BITS-1:0] counter
);

  localparam logic [PWM_COUNTER_BITS-1:0] MIN_CYCLE_W = PWM_COUNTER_BITS'(MIN_CYCLE);
  localparam logic [PWM_COUNTER_BITS-1:0] ONE_W       = PWM_COUNTER_BITS'(1);
  localparam logic                        INV         = INVERT_OUTPUT;

  pwm_state_e                  state;
  logic [PWM_COUNTER_BITS-1:0] cycle_q;
  logic [PWM_COUNTER_BITS-1:0] duty_q;

  logic                        cycle_ok;
  logic                        wrap;
  logic                        load;
  logic                        advance;
  logic [PWM_COUNTER_BITS-1:0] counter_inc;

  always_comb begin
    cycle_ok    = (pwm_cycle >= MIN_CYCLE_W);
    counter_inc = counter + ONE_W;
    wrap        = (state != ST_IDLE) && (counter == cycle_q - ONE_W);
    // A draining block that still sees enable low at the wrap stops; a RUN
    // block reloads even if enable falls on the wrap edge (one extra period).
    load        = cycle_ok &&
                  (((state == ST_IDLE) && enable) ||
                   (wrap && !((state == ST_DRAIN) && !enable)));
    advance     = (state != ST_IDLE) && !wrap;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      counter      <= '0;
      cycle_q      <= '0;
      duty_q       <= '0;
      pwm_out      <= INV;
      period_start <= 1'b0;
      duty_clamped <= 1'b0;
    end else if (load) begin
      state        <= enable ? ST_RUN : ST_DRAIN;
      counter      <= '0;
      cycle_q      <= pwm_cycle;
      duty_q       <= pwm_duty;
      // Output for position 0 comes from the freshly loaded duty.
      pwm_out      <= (pwm_duty != '0) ^ INV;
      period_start <= 1'b1;
      duty_clamped <= (pwm_duty >= pwm_cycle);
    end else if (advance) begin
      state        <= enable ? ST_RUN : ST_DRAIN;
      counter      <= counter_inc;
      pwm_out      <= (counter_inc < duty_q) ^ INV;
      period_start <= 1'b0;
    end else begin
      state        <= ST_IDLE;
      counter      <= '0;
      pwm_out      <= INV;
      period_start <= 1'b0;
      duty_clamped <= 1'b0;
    end
  end

endmodule

// File: tb/tb_phoenix_pwm_generator.sv
// Testbench for phoenix_pwm_generator: two instances (normal and inverted
// output) share the stimulus and are compared against a period-level model.
module tb_phoenix_pwm_generator;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] pwm_cycle;
  logic [W-1:0] pwm_duty;

  logic         out0, ps0, clamp0;
  logic [W-1:0] cnt0;
  logic         out1, ps1, clamp1;
  logic [W-1:0] cnt1;

  always #5 clk = ~clk;

  phoenix_pwm_generator #(.PWM_COUNTER_BITS(W), .MIN_CYCLE(2), .INVERT_OUTPUT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .pwm_cycle(pwm_cycle), .pwm_duty(pwm_duty),
    .pwm_out(out0), .period_start(ps0), .duty_clamped(clamp0), .counter(cnt0)
  );

  phoenix_pwm_generator #(.PWM_COUNTER_BITS(W), .MIN_CYCLE(2), .INVERT_OUTPUT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .pwm_cycle(pwm_cycle), .pwm_duty(pwm_duty),
    .pwm_out(out1), .period_start(ps1), .duty_clamped(clamp1), .counter(cnt1)
  );

  int passes = 0;
  int total  = 0;

  // Period-level reference: running flag, position, latched settings and the
  // enable seen at the previous edge (low means the block is winding down).
  bit          m_running = 0;
  int unsigned m_pos     = 0;
  int unsigned m_cyc     = 0;
  int unsigned m_duty    = 0;
  bit          m_start   = 0;
  bit          m_prev_en = 0;

  int hi_acc = 0;
  int ps_acc = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic begin_period();
    m_cyc     = pwm_cycle;
    m_duty    = pwm_duty;
    m_pos     = 0;
    m_running = 1;
    m_start   = 1;
  endtask

  task automatic model_edge();
    m_start = 0;
    if (!reset) begin
      m_running = 0; m_pos = 0; m_cyc = 0; m_duty = 0;
    end else if (!m_running) begin
      if (enable && pwm_cycle >= 2) begin_period();
    end else if (m_pos + 1 == m_cyc) begin
      // Period complete: stop if enable was low at both this and the
      // previous edge, or if the requested cycle is not runnable.
      if ((!m_prev_en && !enable) || pwm_cycle < 2) begin
        m_running = 0; m_pos = 0;
      end else begin
        begin_period();
      end
    end else begin
      m_pos++;
    end
    m_prev_en = enable;
  endtask

  task automatic step();
    bit act;
    model_edge();
    @(posedge clk);
    #1;
    act = m_running && (m_pos < m_duty);
    chk("counter",        cnt0,   W'(m_running ? m_pos : 0));
    chk("counter_inv",    cnt1,   W'(m_running ? m_pos : 0));
    chk("period_start",   W'(ps0), W'(m_start));
    chk("period_start_i", W'(ps1), W'(m_start));
    chk("pwm_out",        W'(out0), W'(act));
    chk("pwm_out_inv",    W'(out1), W'(!act));
    chk("duty_clamped",   W'(clamp0), W'(m_running && (m_duty >= m_cyc)));
    chk("duty_clamped_i", W'(clamp1), W'(m_running && (m_duty >= m_cyc)));
    hi_acc += int'(out0);
    ps_acc += int'(ps0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; pwm_cycle = '0; pwm_duty = '0;
    steps(3);

    // cycle=10, duty=3: three high cycles per period, start strobe every 10
    reset = 1'b1; pwm_cycle = 10; pwm_duty = 3; enable = 1'b1;
    hi_acc = 0; ps_acc = 0;
    steps(10);
    chk("highs_d3_p1", W'(hi_acc), W'(3));
    hi_acc = 0;
    steps(10);
    chk("highs_d3_p2", W'(hi_acc), W'(3));
    chk("starts_c10", W'(ps_acc), W'(2));

    // duty 3 -> 7 at counter 5: current period keeps 3, next has 7
    hi_acc = 0;
    steps(6);
    chk("mid_counter", cnt0, W'(5));
    pwm_duty = 7;
    steps(4);
    chk("highs_old_duty", W'(hi_acc), W'(3));
    hi_acc = 0;
    steps(10);
    chk("highs_new_duty", W'(hi_acc), W'(7));

    // duty beyond cycle clamps, then duty 0 is always inactive
    pwm_duty = 12;
    hi_acc = 0;
    steps(10);
    chk("highs_clamped", W'(hi_acc), W'(10));
    chk("clamp_flag", W'(clamp0), W'(1));
    pwm_duty = 0;
    hi_acc = 0;
    steps(10);
    chk("highs_zero", W'(hi_acc), W'(0));
    chk("clamp_clear", W'(clamp0), W'(0));

    // cycle below minimum holds idle; cycle=4 starts on the next edge
    pwm_cycle = 1;
    steps(6);
    chk("idle_counter", cnt0, W'(0));
    pwm_cycle = 4; pwm_duty = 2;
    step();
    chk("restart_strobe", W'(ps0), W'(1));

    // enable dropped at counter 2 of an 8-cycle period
    reset = 1'b0; step();
    reset = 1'b1; pwm_cycle = 8; pwm_duty = 5;
    steps(3);
    enable = 1'b0;
    ps_acc = 0;
    steps(5);
    chk("drain_last_pos", cnt0, W'(7));
    steps(3);
    chk("drain_starts", W'(ps_acc), W'(0));
    chk("drain_idle_out", W'(out0), W'(0));

    // enable dropped on the wrap edge: exactly one extra period
    enable = 1'b1;
    step();
    steps(7);
    enable = 1'b0;
    ps_acc = 0;
    steps(12);
    chk("wrap_drop_starts", W'(ps_acc), W'(1));

    // reset mid-period at counter 4
    enable = 1'b1;
    steps(5);
    chk("pre_reset_pos", cnt0, W'(4));
    reset = 1'b0;
    step();
    chk("reset_out_inv", W'(out1), W'(1));
    reset = 1'b1;

    // randomized operation
    pwm_cycle = 6; pwm_duty = 2;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 39) == 0) enable = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 24) == 0) pwm_cycle = $urandom_range(0, 12);
      if ($urandom_range(0, 14) == 0) pwm_duty = $urandom_range(0, 14);
      step();
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
